rosc_freq_meter: RTL and testbench

- Measurement end of the odometer ring-oscillator path: enables a ring oscillator, samples its asynchronous output in the system clock domain and counts its rising edges over a programmable window of system clocks.
- Result is a raw edge count per window, read by the odometer control/readout logic.
- One instance per ring oscillator under test (stressed or reference).

---
 rtl/rosc_freq_meter.sv | 125 ++++++++++++
 tb/tb_rosc_freq_meter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/rosc_freq_meter.sv
// Ring-oscillator frequency meter: enables the oscillator, synchronizes its output into clk
// and counts rising edges over a programmable window after a fixed warm-up.
module rosc_freq_meter #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned WIN_W       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned WARM_CYC    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIN_W-1:0] win_len,
  input  logic             rosc_in,
  output logic             osc_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam int unsigned WARM_W = $clog2(WARM_CYC + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WARMUP  = 2'd1,
    ST_MEASURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   sync_out_c;
  logic                   edge_c;
  logic [WARM_W-1:0]      warm_cnt, warm_nxt;
  logic [WIN_W-1:0]       win_cnt, win_nxt;
  logic [CNT_W-1:0]       count_nxt;
  logic                   ovf_nxt;
  logic                   osc_en_nxt;
  logic                   busy_nxt;
  logic                   done_nxt;

  // Edge detector runs in every state so a level already high at window start is not an edge.
  assign sync_out_c = sync_q[SYNC_STAGES-1];
  assign edge_c     = sync_out_c & ~prev_q;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      sync_q   <= '0;
      prev_q   <= 1'b0;
      warm_cnt <= '0;
      win_cnt  <= '0;
      count    <= '0;
      overflow <= 1'b0;
      osc_en   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      sync_q   <= {sync_q[SYNC_STAGES-2:0], rosc_in};
      prev_q   <= sync_out_c;
      warm_cnt <= warm_nxt;
      win_cnt  <= win_nxt;
      count    <= count_nxt;
      overflow <= ovf_nxt;
      osc_en   <= osc_en_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

  // Next-state and next-output logic; outputs are registered from the next state.
  always_comb begin
    state_nxt = state;
    warm_nxt  = warm_cnt;
    win_nxt   = win_cnt;
    count_nxt = count;
    ovf_nxt   = overflow;

    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_WARMUP;
          warm_nxt  = WARM_W'(WARM_CYC);
          win_nxt   = win_len;
          count_nxt = '0;
          ovf_nxt   = 1'b0;
        end
      end
      ST_WARMUP: begin
        warm_nxt = warm_cnt - WARM_W'(1);
        if (warm_cnt == WARM_W'(1)) begin
          state_nxt = (win_cnt != '0) ? ST_MEASURE : ST_DONE;
        end
      end
      ST_MEASURE: begin
        win_nxt = win_cnt - WIN_W'(1);
        // Saturate: an edge arriving at all-ones is lost and flagged.
        if (edge_c) begin
          if (&count) begin
            ovf_nxt = 1'b1;
          end else begin
            count_nxt = count + CNT_W'(1);
          end
        end
        if (win_cnt == WIN_W'(1)) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    osc_en_nxt = (state_nxt == ST_WARMUP) || (state_nxt == ST_MEASURE);
    busy_nxt   = osc_en_nxt;
    done_nxt   = (state_nxt == ST_DONE);
  end

endmodule

// File: tb/tb_rosc_freq_meter.sv
// Directed bench for rosc_freq_meter: nominal and a 4-bit-count instance sharing clock,
// reset and oscillator stimulus; a cycle index relative to the start cycle T0 drives the checks.
module tb_rosc_freq_meter;

  logic        clk;
  logic        rst_n;
  logic        start_a, start_b;
  logic [15:0] win_len;
  logic        rosc_in;
  logic        osc_en_a, busy_a, done_a, ovf_a;
  logic [15:0] count_a;
  logic        osc_en_b, busy_b, done_b, ovf_b;
  logic [3:0]  count_b;

  int errors = 0;
  int checks = 0;
  int rosc_per = 8;
  logic rosc_lvl = 1'b0;

  rosc_freq_meter #(.CNT_W(16), .WIN_W(16), .SYNC_STAGES(2), .WARM_CYC(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .win_len(win_len), .rosc_in(rosc_in),
    .osc_en(osc_en_a), .busy(busy_a), .done(done_a), .count(count_a), .overflow(ovf_a)
  );

  rosc_freq_meter #(.CNT_W(4), .WIN_W(16), .SYNC_STAGES(2), .WARM_CYC(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .win_len(win_len), .rosc_in(rosc_in),
    .osc_en(osc_en_b), .busy(busy_b), .done(done_b), .count(count_b), .overflow(ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Square wave aligned to clk, or a static level when rosc_per is 0.
  initial begin
    int ph;
    ph = 0;
    rosc_in = 1'b0;
    forever begin
      @(negedge clk);
      if (rosc_per == 0) begin
        rosc_in = rosc_lvl;
      end else begin
        rosc_in = ((ph % rosc_per) < (rosc_per / 2));
        ph++;
      end
    end
  end

  // Raise start for one cycle; the cycle it is high in is T0.
  task automatic kick(input int sel, input int wl);
    @(negedge clk);
    win_len = 16'(wl);
    if (sel == 0) start_a = 1'b1;
    else          start_b = 1'b1;
  endtask

  // Walk cycles T0+1..T0+maxc, recording outputs and injecting extra starts / win_len change.
  task automatic observe(input int sel, input int maxc, input int inj1, input int inj2,
                         input int wl_chg, output int done_cyc, output int done_n,
                         output int busy_n, output int osc_first, output int osc_last,
                         output int cnt_d, output int ovf_d);
    logic b, d, o;
    int c, v;
    done_cyc = -1; done_n = 0; busy_n = 0; osc_first = -1; osc_last = -1;
    cnt_d = -1; ovf_d = -1;
    for (int n = 1; n <= maxc; n++) begin
      @(negedge clk);
      if (sel == 0) begin
        b = busy_a; d = done_a; o = osc_en_a; c = int'(count_a); v = int'(ovf_a);
      end else begin
        b = busy_b; d = done_b; o = osc_en_b; c = int'(count_b); v = int'(ovf_b);
      end
      if (b) busy_n++;
      if (o) begin
        if (osc_first < 0) osc_first = n;
        osc_last = n;
      end
      if (d) begin
        done_n++;
        done_cyc = n;
        cnt_d = c;
        ovf_d = v;
      end
      start_a = 1'b0;
      start_b = 1'b0;
      if (n == inj1 || n == inj2) begin
        if (sel == 0) start_a = 1'b1;
        else          start_b = 1'b1;
      end
      if (n == 1 && wl_chg >= 0) win_len = 16'(wl_chg);
    end
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    settle(3);
    checks++;
    if ({osc_en_a, busy_a, done_a, ovf_a} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 0000", {osc_en_a, busy_a, done_a, ovf_a});
    end
    checks++;
    if (count_a !== 16'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d want 0", count_a);
    end
    checks++;
    if ({osc_en_b, busy_b, done_b, ovf_b, count_b} !== 8'h00) begin
      errors++;
      $display("FAIL reset_b: got %h want 00", {osc_en_b, busy_b, done_b, ovf_b, count_b});
    end
    rst_n = 1'b1;
    settle(20);
  endtask

  task automatic test_square();
    int dc, dn, bn, of, ol, cd, od;
    rosc_per = 8;
    settle(16);
    kick(0, 80);
    observe(0, 100, -1, -1, -1, dc, dn, bn, of, ol, cd, od);
    checks++; if (dc !== 85) begin errors++; $display("FAIL sq_done_cycle: got %0d want 85", dc); end
    checks++; if (dn !== 1)  begin errors++; $display("FAIL sq_done_pulses: got %0d want 1", dn); end
    checks++; if (bn !== 84) begin errors++; $display("FAIL sq_busy_cycles: got %0d want 84", bn); end
    checks++; if (cd !== 10) begin errors++; $display("FAIL sq_count: got %0d want 10", cd); end
    checks++; if (od !== 0)  begin errors++; $display("FAIL sq_overflow: got %0d want 0", od); end
  endtask

  task automatic test_saturation();
    int dc, dn, bn, of, ol, cd, od;
    rosc_per = 4;
    settle(16);
    kick(1, 100);
    observe(1, 120, -1, -1, -1, dc, dn, bn, of, ol, cd, od);
    checks++; if (dc !== 105) begin errors++; $display("FAIL sat_done_cycle: got %0d want 105", dc); end
    checks++; if (cd !== 15)  begin errors++; $display("FAIL sat_count: got %0d want 15", cd); end
    checks++; if (od !== 1)   begin errors++; $display("FAIL sat_overflow: got %0d want 1", od); end
    settle(10);
    checks++;
    if ({ovf_b, count_b} !== 5'b1_1111) begin
      errors++;
      $display("FAIL sat_hold: got %b want 11111", {ovf_b, count_b});
    end
    // A new zero-length start clears the held result.
    kick(1, 0);
    observe(1, 10, -1, -1, -1, dc, dn, bn, of, ol, cd, od);
    checks++;
    if (cd !== 0 || od !== 0) begin
      errors++;
      $display("FAIL sat_clear: got count %0d ovf %0d want 0 0", cd, od);
    end
  endtask

  task automatic test_zero_window();
    int dc, dn, bn, of, ol, cd, od;
    rosc_per = 4;
    settle(8);
    kick(0, 0);
    observe(0, 15, -1, -1, -1, dc, dn, bn, of, ol, cd, od);
    checks++; if (of !== 1 || ol !== 4) begin errors++; $display("FAIL zero_osc_en: got T%0d..T%0d want T1..T4", of, ol); end
    checks++; if (dc !== 5) begin errors++; $display("FAIL zero_done_cycle: got %0d want 5", dc); end
    checks++; if (bn !== 4) begin errors++; $display("FAIL zero_busy_cycles: got %0d want 4", bn); end
    checks++; if (cd !== 0 || od !== 0) begin errors++; $display("FAIL zero_result: got %0d/%0d want 0/0", cd, od); end
  endtask

  task automatic test_static();
    int dc, dn, bn, of, ol, cd, od;
    rosc_per = 0;
    rosc_lvl = 1'b1;
    settle(8);
    kick(0, 50);
    observe(0, 70, -1, -1, -1, dc, dn, bn, of, ol, cd, od);
    checks++; if (dc !== 55) begin errors++; $display("FAIL static_done_cycle: got %0d want 55", dc); end
    checks++; if (cd !== 0)  begin errors++; $display("FAIL static_count: got %0d want 0", cd); end
    rosc_lvl = 1'b0;
  endtask

  task automatic test_back_to_back();
    int dc, dn, bn, of, ol, cd, od;
    rosc_per = 8;
    settle(16);
    kick(0, 80);
    observe(0, 110, 10, 85, 5, dc, dn, bn, of, ol, cd, od);
    checks++; if (dc !== 85) begin errors++; $display("FAIL b2b_done_cycle: got %0d want 85", dc); end
    checks++; if (dn !== 1)  begin errors++; $display("FAIL b2b_done_pulses: got %0d want 1", dn); end
    checks++; if (bn !== 84) begin errors++; $display("FAIL b2b_busy_cycles: got %0d want 84", bn); end
    checks++; if (cd !== 10) begin errors++; $display("FAIL b2b_count: got %0d want 10", cd); end
  endtask

  task automatic test_reset_mid();
    int dc, dn, bn, of, ol, cd, od;
    rosc_per = 8;
    settle(16);
    kick(0, 80);
    observe(0, 29, -1, -1, -1, dc, dn, bn, of, ol, cd, od);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({osc_en_a, busy_a, done_a, ovf_a} !== 4'b0000 || count_a !== 16'd0) begin
      errors++;
      $display("FAIL rstmid_outputs: got flags %b count %0d want 0000 0",
               {osc_en_a, busy_a, done_a, ovf_a}, count_a);
    end
    settle(3);
    rst_n = 1'b1;
    settle(10);
    kick(0, 16);
    observe(0, 30, -1, -1, -1, dc, dn, bn, of, ol, cd, od);
    checks++; if (dc !== 21) begin errors++; $display("FAIL rstmid_done_cycle: got %0d want 21", dc); end
    checks++; if (cd !== 2)  begin errors++; $display("FAIL rstmid_count: got %0d want 2", cd); end
  endtask

  initial begin
    start_a = 1'b0;
    start_b = 1'b0;
    win_len = 16'd0;
    rst_n   = 1'b0;
    test_reset();
    test_square();
    test_saturation();
    test_zero_window();
    test_static();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
